avalon_ram_responder: RTL and testbench
=======================================

Name: avalon_ram_responder

Overview:
- Avalon-MM slave word RAM that answers the CPU bus master's read/write requests with programmable waitrequest stalls.
- Used as instruction/data memory in CPU testbenches and FPGA builds; it is the responder end of the CPU's Avalon interface.
- Supports byte-enabled writes, a registered read return and an optional pseudo-random stall mode, so master stall handling can be exercised.

Parameters:
- BASE_ADDR, 32'hBFC00000, byte address of word 0 (MIPS reset vector).
- DEPTH, 1024, number of 32-bit words; power of two, 16..65536.
- WAIT_CYCLES, 2, maximum waitrequest cycles per request (0..15).
- RANDOM_WAIT, 0, 0: every request stalls exactly WAIT_CYCLES; 1: stall drawn per request from LFSR, range 0..WAIT_CYCLES.
- INIT_FILE, "", hex file loaded with $readmemh at time 0 if non-empty.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- read  in  1  master read request.
- write  in  1  master write request.
- address  in  32  byte address; bits [1:0] ignored.
- byteenable  in  4  lane enables; bit n covers writedata[8n+7:8n].
- writedata  in  32  write data.
- waitrequest  out  1  stall; request is accepted in the cycle where (read|write) && !waitrequest.
- readdata  out  32  read return data.
- fault  out  1  sticky protocol/range error flag.

Behaviour:
- Reset values: readdata=0, fault=0, stall counter=0, target=0, LFSR=16'hACE1, FSM=IDLE.
- RAM contents are not cleared by reset.
- Sync reset mid-request discards the request with no write and no readdata update. The master must re-present the request.
- req = read|write.
- FSM states: IDLE, STALL.
- IDLE with req: load target. target = WAIT_CYCLES, or LFSR[3:0] mod (WAIT_CYCLES+1) if RANDOM_WAIT.
  - target==0: waitrequest=0 combinationally and the request is accepted this cycle; stay in IDLE.
  - Otherwise: go to STALL with cnt=1.
- IDLE waitrequest = req && (computed target != 0). This path is combinational from read/write/LFSR.
- STALL: waitrequest = (cnt < target).
  - Each cycle with cnt < target: cnt++.
  - Cycle with cnt == target: waitrequest=0, request accepted, next state IDLE, cnt=0.
- Master drops req while in STALL (protocol violation): return to IDLE, set fault, no access.
- Address/control must stay stable while waitrequest=1. Changes are not checked; the values present in the accept cycle are used.
- LFSR: x^16+x^14+x^13+x^11 Galois, advances every cycle when not in reset.
- Range decode: hit when BASE_ADDR <= address < BASE_ADDR + 4*DEPTH. word = (address - BASE_ADDR) >> 2.
- Accepted write, hit: at the accept edge, mem[word] byte lanes with byteenable=1 take writedata; other lanes are unchanged. byteenable=0000 leaves the word unchanged and is not a fault.
- Accepted read, hit: readdata <= mem[word] at the accept edge. Read latency is therefore 1 cycle: valid the cycle after accept.
- readdata holds its value until the next accepted read. Writes do not alter readdata, even to the same word.
- Accepted read, miss: readdata <= 0, fault <= 1.
- Accepted write, miss: ignored, fault <= 1.
- read && write both high: treated as read only, write suppressed, fault <= 1.
- Back-to-back requests: a new request may begin in the cycle after accept and gets a fresh target. Throughput is 1 word/cycle when target==0.
- Read-after-write to the same word in consecutive accepts returns the new data; no bypass hazard, since the write commits at the earlier edge.
- fault clears only on reset.

Test Plan:
- WAIT_CYCLES=0, write 0xDEADBEEF to 0xBFC00010 with byteenable=1111, then read 0xBFC00010 -> waitrequest never 1; readdata=0xDEADBEEF the cycle after read accept.
- WAIT_CYCLES=3, read held from cycle 0 -> waitrequest=1 in cycles 0-2, 0 in cycle 3; readdata updated in cycle 4; fault=0.
- Word 0 = 0x11223344, write 0xAABBCCDD with byteenable=0101 -> readback 0x11BB33DD.
- Read 0x00000000 (below BASE) and write 0xBFC01000 (one past end, DEPTH=1024) -> readdata=0, memory unchanged, fault=1 and stays 1 until reset.
- RANDOM_WAIT=1, WAIT_CYCLES=7, 200 random reads/writes against a scoreboard -> every stall 0..7 cycles, all read data matches, at least 4 distinct stall lengths seen.
- Assert reset during cycle 1 of a 3-cycle stalled write -> no memory change, readdata=0, FSM IDLE; re-issued write completes normally.

Source files
------------

// File: rtl/avalon_ram_responder.sv
// Avalon-MM slave word RAM with byte-enabled writes, a registered read
// return and programmable (fixed or LFSR-drawn) waitrequest stalls.
// Out-of-range accesses, read+write collisions and requests dropped
// mid-stall raise a sticky fault flag.
module avalon_ram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter int          RANDOM_WAIT = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        fault
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [32:0] SPAN      = 33'(DEPTH) << 2;
    localparam logic [4:0]  WAIT_MOD  = 5'(WAIT_CYCLES + 1);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois taps for x^16 + x^14 + x^13 + x^11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        IDLE,
        STALL
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    target_q, target_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [31:0]   readdata_q, readdata_d;
    logic          fault_q, fault_d;

    logic          req;
    logic          accept;
    logic          drop_fault;
    logic [3:0]    fresh_target;
    logic [31:0]   offset;
    logic          hit;
    logic [AW-1:0] word;
    logic          mem_we;

    logic [31:0]   mem [DEPTH];

    // Address decode and the stall length a request starting this cycle would get.
    always_comb begin
        req    = read | write;
        offset = address - BASE_ADDR;
        hit    = (address >= BASE_ADDR) && ({1'b0, offset} < SPAN);
        word   = offset[AW+1:2];
        if (RANDOM_WAIT != 0) begin
            fresh_target = 4'({1'b0, lfsr_q[3:0]} % WAIT_MOD);
        end else begin
            fresh_target = 4'(WAIT_CYCLES);
        end
    end

    // Handshake FSM next-state logic; waitrequest is combinational from req in IDLE.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        target_d    = target_q;
        waitrequest = 1'b0;
        accept      = 1'b0;
        drop_fault  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    target_d = fresh_target;
                    if (fresh_target == 4'd0) begin
                        accept = 1'b1;
                    end else begin
                        waitrequest = 1'b1;
                        state_d     = STALL;
                        cnt_d       = 4'd1;
                    end
                end
            end
            STALL: begin
                waitrequest = (cnt_q < target_q);
                if (!req) begin
                    // Master abandoned a stalled request: no access, flag it.
                    state_d    = IDLE;
                    cnt_d      = 4'd0;
                    drop_fault = 1'b1;
                end else if (cnt_q < target_q) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    accept  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Access side effects of an accepted request, plus free-running LFSR.
    always_comb begin
        readdata_d = readdata_q;
        fault_d    = fault_q | drop_fault;
        mem_we     = 1'b0;
        lfsr_d     = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        if (accept) begin
            if (read) begin
                // A simultaneous write is suppressed; the read wins.
                readdata_d = hit ? mem[word] : 32'h0;
                if (!hit || write) begin
                    fault_d = 1'b1;
                end
            end else if (hit) begin
                mem_we = !reset;
            end else begin
                fault_d = 1'b1;
            end
        end
    end

    // Control and status registers; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            target_q   <= 4'd0;
            lfsr_q     <= LFSR_SEED;
            readdata_q <= 32'h0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            target_q   <= target_d;
            lfsr_q     <= lfsr_d;
            readdata_q <= readdata_d;
            fault_q    <= fault_d;
        end
    end

    // Byte-lane write into the word array.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so it can map onto block RAM; contents survive reset.
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    mem[word][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    assign readdata = readdata_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_avalon_ram_responder.sv
// Bench for avalon_ram_responder: three instances (no stall, fixed 3-cycle
// stall, random 0..7 stall) checked every cycle against a transaction-level
// model, plus directed literal expectations.
module tb_avalon_ram_responder;

    localparam logic [31:0] BASE = 32'hBFC00000;

    logic        clk;
    logic [2:0]  rst_v;
    logic [2:0]  rd_v;
    logic [2:0]  wr_v;
    logic [2:0]  wait_v;
    logic [2:0]  fault_v;
    logic [31:0] addr_v  [3];
    logic [3:0]  be_v    [3];
    logic [31:0] wd_v    [3];
    logic [31:0] rdata_v [3];

    int n_pass   = 0;
    int n_checks = 0;

    avalon_ram_responder #(
        .BASE_ADDR(BASE), .DEPTH(1024), .WAIT_CYCLES(0), .RANDOM_WAIT(0), .INIT_FILE("")
    ) u_w0 (
        .clk(clk), .reset(rst_v[0]), .read(rd_v[0]), .write(wr_v[0]),
        .address(addr_v[0]), .byteenable(be_v[0]), .writedata(wd_v[0]),
        .waitrequest(wait_v[0]), .readdata(rdata_v[0]), .fault(fault_v[0])
    );

    avalon_ram_responder #(
        .BASE_ADDR(BASE), .DEPTH(1024), .WAIT_CYCLES(3), .RANDOM_WAIT(0), .INIT_FILE("")
    ) u_w3 (
        .clk(clk), .reset(rst_v[1]), .read(rd_v[1]), .write(wr_v[1]),
        .address(addr_v[1]), .byteenable(be_v[1]), .writedata(wd_v[1]),
        .waitrequest(wait_v[1]), .readdata(rdata_v[1]), .fault(fault_v[1])
    );

    avalon_ram_responder #(
        .BASE_ADDR(BASE), .DEPTH(1024), .WAIT_CYCLES(7), .RANDOM_WAIT(1), .INIT_FILE("")
    ) u_rnd (
        .clk(clk), .reset(rst_v[2]), .read(rd_v[2]), .write(wr_v[2]),
        .address(addr_v[2]), .byteenable(be_v[2]), .writedata(wd_v[2]),
        .waitrequest(wait_v[2]), .readdata(rdata_v[2]), .fault(fault_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    function automatic int wc_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 3 : 7);
    endfunction

    function automatic bit rnd_of(input int i);
        return i == 2;
    endfunction

    // One step of the x^16+x^14+x^13+x^11 Galois register.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    logic [31:0] m_mem [int];
    logic [15:0] m_lfsr   [3];
    bit          m_live   [3];
    bit          m_busy   [3];
    int          m_need   [3];
    int          m_waited [3];
    logic [31:0] m_rdata  [3];
    bit          m_fault  [3];

    logic        t_req;
    int          t_need;
    int          t_waited;
    longint      t_off;
    bit          t_hit;
    int          t_key;
    logic [31:0] t_old;

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_live[i] = 1'b0;
            m_busy[i] = 1'b0;
        end
    end

    // Per-cycle compare of all instances, then advance the model across the coming edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            t_req    = rd_v[i] | wr_v[i];
            t_need   = m_busy[i] ? m_need[i]
                     : (rnd_of(i) ? int'(m_lfsr[i][3:0]) % (wc_of(i) + 1) : wc_of(i));
            t_waited = m_busy[i] ? m_waited[i] : 0;
            if (m_live[i]) begin
                if (!$isunknown(m_rdata[i]))
                    check($sformatf("model_readdata_%0d", i), rdata_v[i], m_rdata[i]);
                check($sformatf("model_fault_%0d", i), {31'b0, fault_v[i]}, {31'b0, m_fault[i]});
                if (t_req)
                    check($sformatf("model_wait_%0d", i), {31'b0, wait_v[i]},
                          {31'b0, (t_waited < t_need)});
            end
            if (rst_v[i]) begin
                m_live[i]   = 1'b1;
                m_busy[i]   = 1'b0;
                m_waited[i] = 0;
                m_lfsr[i]   = 16'hACE1;
                m_rdata[i]  = 32'h0;
                m_fault[i]  = 1'b0;
            end else if (m_live[i]) begin
                m_lfsr[i] = lfsr_step(m_lfsr[i]);
                if (m_busy[i] && !t_req) begin
                    m_busy[i]  = 1'b0;
                    m_fault[i] = 1'b1;
                end else if (t_req && (t_waited < t_need)) begin
                    m_busy[i]   = 1'b1;
                    m_need[i]   = t_need;
                    m_waited[i] = t_waited + 1;
                end else if (t_req) begin
                    m_busy[i] = 1'b0;
                    t_off = longint'(addr_v[i]) - longint'(BASE);
                    t_hit = (t_off >= 0) && (t_off < 4 * 1024);
                    t_key = i * 65536 + int'(t_off >>> 2);
                    if (rd_v[i]) begin
                        m_rdata[i] = !t_hit ? 32'h0
                                   : (m_mem.exists(t_key) ? m_mem[t_key] : 32'hx);
                        if (!t_hit || wr_v[i]) m_fault[i] = 1'b1;
                    end else if (t_hit) begin
                        t_old = m_mem.exists(t_key) ? m_mem[t_key] : 32'hx;
                        for (int b = 0; b < 4; b++)
                            if (be_v[i][b]) t_old[8*b +: 8] = wd_v[i][8*b +: 8];
                        m_mem[t_key] = t_old;
                    end else begin
                        m_fault[i] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Present a request (called just after a rising edge), hold it until accepted,
    // then release the bus right after the accept edge.
    task automatic do_req(input int i, input logic r, input logic w, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] d, output int stalls);
        bit done;
        done      = 1'b0;
        stalls    = 0;
        rd_v[i]   = r;
        wr_v[i]   = w;
        addr_v[i] = a;
        be_v[i]   = be;
        wd_v[i]   = d;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!wait_v[i]) done = 1'b1;
            else stalls++;
        end
        check("req_accepted", {31'b0, done}, 32'd1);
        @(posedge clk);
        #1;
        rd_v[i] = 1'b0;
        wr_v[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int          st;
    bit          seen [16];
    logic [31:0] sb   [16];
    int          n_distinct;
    int          k;
    logic [31:0] d;
    logic [3:0]  be;

    initial begin
        rst_v = 3'b111;
        rd_v  = 3'b000;
        wr_v  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addr_v[i] = 32'h0;
            be_v[i]   = 4'h0;
            wd_v[i]   = 32'h0;
        end
        for (int s = 0; s < 16; s++) seen[s] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_v = 3'b000;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_readdata", rdata_v[i], 32'h0);
            check("reset_fault", {31'b0, fault_v[i]}, 32'd0);
        end
        idle(1);

        // ---- zero-wait instance ----
        do_req(0, 1'b0, 1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF, st);
        check("w0_write_stall", st, 0);
        do_req(0, 1'b1, 1'b0, BASE + 32'h10, 4'hF, 32'h0, st);
        check("w0_read_stall", st, 0);
        check("w0_read_data", rdata_v[0], 32'hDEADBEEF);
        do_req(0, 1'b0, 1'b1, BASE + 32'h14, 4'hF, 32'h01234567, st);
        do_req(0, 1'b1, 1'b0, BASE + 32'h14, 4'hF, 32'h0, st);
        check("w0_raw_data", rdata_v[0], 32'h01234567);
        do_req(0, 1'b0, 1'b1, BASE + 32'h14, 4'h0, 32'hFFFFFFFF, st);
        do_req(0, 1'b1, 1'b0, BASE + 32'h14, 4'hF, 32'h0, st);
        check("w0_be0_unchanged", rdata_v[0], 32'h01234567);
        check("w0_be0_no_fault", {31'b0, fault_v[0]}, 32'd0);
        do_req(0, 1'b1, 1'b1, BASE + 32'h10, 4'hF, 32'h0, st);
        check("w0_rw_read", rdata_v[0], 32'hDEADBEEF);
        check("w0_rw_fault", {31'b0, fault_v[0]}, 32'd1);
        do_req(0, 1'b1, 1'b0, BASE + 32'h10, 4'hF, 32'h0, st);
        check("w0_rw_write_suppressed", rdata_v[0], 32'hDEADBEEF);

        // ---- fixed 3-cycle instance ----
        do_req(1, 1'b0, 1'b1, BASE, 4'hF, 32'h11223344, st);
        check("w3_write_stall", st, 3);
        do_req(1, 1'b1, 1'b0, BASE, 4'hF, 32'h0, st);
        check("w3_read_stall", st, 3);
        check("w3_read_data", rdata_v[1], 32'h11223344);
        check("w3_no_fault", {31'b0, fault_v[1]}, 32'd0);
        do_req(1, 1'b0, 1'b1, BASE, 4'b0101, 32'hAABBCCDD, st);
        do_req(1, 1'b1, 1'b0, BASE, 4'hF, 32'h0, st);
        check("w3_byte_lanes", rdata_v[1], 32'h11BB33DD);
        do_req(1, 1'b1, 1'b0, 32'h00000000, 4'hF, 32'h0, st);
        check("w3_miss_read_data", rdata_v[1], 32'h0);
        check("w3_miss_read_fault", {31'b0, fault_v[1]}, 32'd1);
        do_req(1, 1'b0, 1'b1, BASE + 32'h1000, 4'hF, 32'hCAFEF00D, st);
        do_req(1, 1'b1, 1'b0, BASE, 4'hF, 32'h0, st);
        check("w3_miss_write_no_alias", rdata_v[1], 32'h11BB33DD);
        idle(5);
        check("w3_fault_sticky", {31'b0, fault_v[1]}, 32'd1);

        // Reset lands in cycle 1 of a stalled write.
        wr_v[1]   = 1'b1;
        addr_v[1] = BASE;
        be_v[1]   = 4'hF;
        wd_v[1]   = 32'h55555555;
        @(posedge clk);
        #1;
        rst_v[1] = 1'b1;
        @(posedge clk);
        #1;
        rst_v[1] = 1'b0;
        wr_v[1]  = 1'b0;
        check("rst_mid_readdata", rdata_v[1], 32'h0);
        check("rst_mid_fault", {31'b0, fault_v[1]}, 32'd0);
        do_req(1, 1'b1, 1'b0, BASE, 4'hF, 32'h0, st);
        check("rst_mid_fresh_stall", st, 3);
        check("rst_mid_no_write", rdata_v[1], 32'h11BB33DD);
        do_req(1, 1'b0, 1'b1, BASE, 4'hF, 32'h55555555, st);
        check("rst_reissue_stall", st, 3);
        do_req(1, 1'b1, 1'b0, BASE, 4'hF, 32'h0, st);
        check("rst_reissue_data", rdata_v[1], 32'h55555555);

        // Write abandoned mid-stall.
        wr_v[1]   = 1'b1;
        addr_v[1] = BASE;
        be_v[1]   = 4'hF;
        wd_v[1]   = 32'h0BADF00D;
        @(posedge clk);
        #1;
        wr_v[1] = 1'b0;
        @(posedge clk);
        #1;
        check("drop_fault", {31'b0, fault_v[1]}, 32'd1);
        do_req(1, 1'b1, 1'b0, BASE, 4'hF, 32'h0, st);
        check("drop_no_write", rdata_v[1], 32'h55555555);

        // ---- random-stall instance ----
        for (int w = 0; w < 16; w++) begin
            sb[w] = $urandom;
            do_req(2, 1'b0, 1'b1, BASE + 32'(4 * w), 4'hF, sb[w], st);
            check("rnd_stall_range", {31'b0, (st <= 7)}, 32'd1);
            if (st < 16) seen[st] = 1'b1;
        end
        for (int n = 0; n < 200; n++) begin
            k = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 0) begin
                do_req(2, 1'b1, 1'b0, BASE + 32'(4 * k), 4'hF, 32'h0, st);
                check("rnd_read_data", rdata_v[2], sb[k]);
            end else begin
                d  = $urandom;
                be = 4'($urandom_range(0, 15));
                do_req(2, 1'b0, 1'b1, BASE + 32'(4 * k), be, d, st);
                for (int b = 0; b < 4; b++)
                    if (be[b]) sb[k][8*b +: 8] = d[8*b +: 8];
            end
            check("rnd_stall_range", {31'b0, (st <= 7)}, 32'd1);
            if (st < 16) seen[st] = 1'b1;
        end
        n_distinct = 0;
        for (int s = 0; s < 16; s++) if (seen[s]) n_distinct++;
        check("rnd_distinct_stalls", {31'b0, (n_distinct >= 4)}, 32'd1);
        check("rnd_no_fault", {31'b0, fault_v[2]}, 32'd0);

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
